nibble_add_sched: RTL

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

---
 rtl/nibble_add_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/nibble_add_sched.sv
// Two-requester adder that reuses one 4-bit adder, one nibble per cycle, LSB first.
// Define NIBBLE_ADD_SCHED_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant on the exit edge
// ADD   | one nibble summed per cycle into the accumulator
// DONE  | result visible, done pulse to the owner
module nibble_add_sched #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [4*NIB-1:0] a0,
    input  logic [4*NIB-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [4*NIB-1:0] a1,
    input  logic [4*NIB-1:0] b1,
    input  logic             cin1,
    output logic [4*NIB-1:0] sum,
    output logic             cout,
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    output logic             ovf,
`endif
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             owner
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic            gnt;
    logic [3:0]      nib_a, nib_b;
    logic [4:0]      add_res;

    // The single shared adder: operand nibble selected by the index register.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int k = 0; k < NIB; k++) begin
            if (idx_q == IW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
        add_res = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        owner_d = owner_q;
        prio_d  = prio_q;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
        ovf_d   = ovf_q;
`endif
        gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // prio_q high means requester 1 wins a tie.
                    gnt     = req1 & (~req0 | prio_q);
                    state_d = ADD;
                    owner_d = gnt;
                    prio_d  = ~gnt;
                    a_d     = gnt ? a1 : a0;
                    b_d     = gnt ? b1 : b0;
                    carry_d = gnt ? cin1 : cin0;
                    idx_d   = '0;
                end
            end
            ADD: begin
                for (int k = 0; k < NIB; k++) begin
                    if (idx_q == IW'(k)) begin
                        acc_d[4*k +: 4] = add_res[3:0];
                    end
                end
                carry_d = add_res[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NIB - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = add_res[4];
`ifdef NIBBLE_ADD_SCHED_OVF_EN
                    // Carry into the MSB recovered from the top nibble's bit 3.
                    ovf_d   = (nib_a[3] ^ nib_b[3] ^ add_res[3]) ^ add_res[4];
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum   = sum_q;
    assign cout  = cout_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);
    assign done0 = (state_q == DONE) && !owner_q;
    assign done1 = (state_q == DONE) && owner_q;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule
